// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC rotation pipeline: angle scaling,
// quadrant encoding and the saturating negation helper.
package cordic_pkg;

  // Default port widths for the pipeline.
  localparam int DATA_W_DEF  = 16;
  localparam int ANGLE_W_DEF = 16;

  // Turn-scaled angle: 15 significant bits cover one full revolution.
  localparam int ANGLE_TURN_W = 15;
  // Residual angle after folding into the first quadrant: 13 bits.
  localparam int ANGLE_RES_W  = 13;

  localparam int unsigned ANGLE_FULL_TURN = 32768;
  localparam int unsigned ANGLE_PI_HALF   = 8192;
  localparam int unsigned ANGLE_PI        = 16384;
  localparam int unsigned ANGLE_3PI_HALF  = 24576;

  // Multiple of pi/2 removed from the angle.
  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_e;

  // Saturating negation at the default sample width: the most negative
  // code has no positive counterpart and clamps to the largest positive.
  function automatic logic signed [DATA_W_DEF-1:0] sat_neg(
    input logic signed [DATA_W_DEF-1:0] v
  );
    logic signed [DATA_W_DEF-1:0] most_neg;
    logic signed [DATA_W_DEF-1:0] most_pos;
    most_neg = {1'b1, {(DATA_W_DEF-1){1'b0}}};
    most_pos = {1'b0, {(DATA_W_DEF-1){1'b1}}};
    if (v == most_neg) begin
      return most_pos;
    end
    return -v;
  endfunction

endpackage

// File: rtl/cordic_quadrant_rotate.sv
// Rotates a signed vector counter-clockwise by q*pi/2. Purely combinational;
// negations saturate so the result never needs an extra bit. Shared by the
// input standardizer and the output de-standardizer.
module cordic_quadrant_rotate
  import cordic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [DATA_W-1:0] y_i,
  input  quadrant_e                quad_i,
  output logic signed [DATA_W-1:0] x_o,
  output logic signed [DATA_W-1:0] y_o
);

  // Width-generic saturating negation; -(most negative) clamps to max.
  function automatic logic signed [DATA_W-1:0] neg_sat(
    input logic signed [DATA_W-1:0] v
  );
    logic signed [DATA_W-1:0] most_neg;
    logic signed [DATA_W-1:0] most_pos;
    most_neg = {1'b1, {(DATA_W-1){1'b0}}};
    most_pos = {1'b0, {(DATA_W-1){1'b1}}};
    if (v == most_neg) begin
      return most_pos;
    end
    return -v;
  endfunction

  logic signed [DATA_W-1:0] neg_x;
  logic signed [DATA_W-1:0] neg_y;

  assign neg_x = neg_sat(x_i);
  assign neg_y = neg_sat(y_i);

  // Select the rotated components; every quadrant is a swap and/or sign flip.
  always_comb begin
    x_o = x_i;
    y_o = y_i;
    unique case (quad_i)
      Q0: begin
        x_o = x_i;
        y_o = y_i;
      end
      Q1: begin
        x_o = neg_y;
        y_o = x_i;
      end
      Q2: begin
        x_o = neg_x;
        y_o = neg_y;
      end
      Q3: begin
        x_o = y_i;
        y_o = neg_x;
      end
      default: begin
        x_o = x_i;
        y_o = y_i;
      end
    endcase
  end

endmodule

// File: rtl/cordic_input_standardizer.sv
// Front end of the rotation-mode CORDIC: folds the turn-scaled angle into
// [0, pi/2), pre-rotates the vector by the removed multiple of pi/2 and
// reports that quadrant. One register stage, valid strobe, no backpressure.
module cordic_input_standardizer
  import cordic_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ANGLE_W = ANGLE_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic signed [DATA_W-1:0]  x_in,
  input  logic signed [DATA_W-1:0]  y_in,
  input  logic        [ANGLE_W-1:0] theta_in,
  output logic                      out_valid,
  output logic signed [DATA_W-1:0]  x_out,
  output logic signed [DATA_W-1:0]  y_out,
  output logic        [ANGLE_W-1:0] theta_out,
  output logic        [1:0]         quadrant
);

  // Angle bits above one full turn are wrap-around and carry no information.
  logic unused_theta_hi;
  assign unused_theta_hi = ^theta_in[ANGLE_W-1:ANGLE_TURN_W];

  // Angle fold: the top two in-turn bits are the quadrant, the rest is the
  // residual. Exact multiples of pi/2 naturally give residual 0.
  quadrant_e                quad_in;
  logic [ANGLE_RES_W-1:0]   theta_res;

  assign quad_in   = quadrant_e'(theta_in[ANGLE_TURN_W-1:ANGLE_RES_W]);
  assign theta_res = theta_in[ANGLE_RES_W-1:0];

  logic signed [DATA_W-1:0] x_rot;
  logic signed [DATA_W-1:0] y_rot;

  cordic_quadrant_rotate #(
    .DATA_W (DATA_W)
  ) u_rotate (
    .x_i    (x_in),
    .y_i    (y_in),
    .quad_i (quad_in),
    .x_o    (x_rot),
    .y_o    (y_rot)
  );

  // Output register bank and its next-state values.
  logic                      vld_q;
  logic signed [DATA_W-1:0]  x_q,     x_d;
  logic signed [DATA_W-1:0]  y_q,     y_d;
  logic        [ANGLE_W-1:0] theta_q, theta_d;
  quadrant_e                 quad_q,  quad_d;

  // Capture a new sample only when one is offered; otherwise hold.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    theta_d = theta_q;
    quad_d  = quad_q;
    if (in_valid) begin
      x_d     = x_rot;
      y_d     = y_rot;
      theta_d = {{(ANGLE_W-ANGLE_RES_W){1'b0}}, theta_res};
      quad_d  = quad_in;
    end
  end

  // Single pipeline register; reset clears everything and drops any sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      theta_q <= '0;
      quad_q  <= Q0;
    end else begin
      vld_q   <= in_valid;
      x_q     <= x_d;
      y_q     <= y_d;
      theta_q <= theta_d;
      quad_q  <= quad_d;
    end
  end

  assign out_valid = vld_q;
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign theta_out = theta_q;
  assign quadrant  = quad_q;

endmodule

// File: tb/tb_cordic_input_standardizer.sv
// Directed, table-driven bench for cordic_input_standardizer.
module tb_cordic_input_standardizer;

  localparam int DW = 16;
  localparam int AW = 16;

  logic                  clk;
  logic                  rst_n;
  logic                  in_valid;
  logic signed [DW-1:0]  x_in;
  logic signed [DW-1:0]  y_in;
  logic        [AW-1:0]  theta_in;
  logic                  out_valid;
  logic signed [DW-1:0]  x_out;
  logic signed [DW-1:0]  y_out;
  logic        [AW-1:0]  theta_out;
  logic        [1:0]     quadrant;

  int checks;
  int errors;

  cordic_input_standardizer #(
    .DATA_W  (DW),
    .ANGLE_W (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .x_in      (x_in),
    .y_in      (y_in),
    .theta_in  (theta_in),
    .out_valid (out_valid),
    .x_out     (x_out),
    .y_out     (y_out),
    .theta_out (theta_out),
    .quadrant  (quadrant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int theta;
    int ex;
    int ey;
    int etheta;
    int eq;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int ev, input int ex,
                           input int ey, input int eth, input int eq);
    chk({tag, " out_valid"}, int'(out_valid), ev);
    chk({tag, " x_out"},     int'($signed(x_out)), ex);
    chk({tag, " y_out"},     int'($signed(y_out)), ey);
    chk({tag, " theta_out"}, int'(theta_out), eth);
    chk({tag, " quadrant"},  int'(quadrant), eq);
  endtask

  // Drive one sample on the falling edge; outputs are sampled 1 after the next rise.
  task automatic drive(input bit v, input int x, input int y, input int th);
    @(negedge clk);
    in_valid = v;
    x_in     = DW'(x);
    y_in     = DW'(y);
    theta_in = AW'(th);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //              x       y       theta   ex      ey      eth   q
    vecs[0]  = '{ 16384,      0,      0,  16384,      0,    0, 0};
    vecs[1]  = '{ 16384,      0,    100,  16384,      0,  100, 0};
    vecs[2]  = '{ 10000,   5000,   8192,  -5000,  10000,    0, 1};
    vecs[3]  = '{ 10000,   5000,   8193,  -5000,  10000,    1, 1};
    vecs[4]  = '{ 12000, -12000,  16384, -12000,  12000,    0, 2};
    vecs[5]  = '{  2000,   3000,  24576,   3000,  -2000,    0, 3};
    vecs[6]  = '{-15000,   8000,  32767,   8000,  15000, 8191, 3};
    vecs[7]  = '{ 20000,   1000,  32768,  20000,   1000,    0, 0};
    vecs[8]  = '{ 32767, -32767,  25000, -32767, -32767,  424, 3};
    vecs[9]  = '{     0, -32768,   8192,  32767,      0,    0, 1};
    vecs[10] = '{    -1,     -1,      1,     -1,     -1,    1, 0};
    vecs[11] = '{-32768,      5,  16391,  32767,     -5,    7, 2};
    vecs[12] = '{-32768,    100,  65535,    100,  32767, 8191, 3};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    x_in     = '0;
    y_in     = '0;
    theta_in = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of single-sample vectors
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, vecs[i].x, vecs[i].y, vecs[i].theta);
      check_out($sformatf("vec%0d", i), 1, vecs[i].ex, vecs[i].ey,
                vecs[i].etheta, vecs[i].eq);
    end

    // Valid gating: three back-to-back samples, one idle cycle, then another
    drive(1'b1, 100, 200, 300);
    check_out("burst0", 1, 100, 200, 300, 0);
    drive(1'b1, 100, 200, 8192 + 5);
    check_out("burst1", 1, -200, 100, 5, 1);
    drive(1'b1, 7, -9, 16384 + 11);
    check_out("burst2", 1, -7, 9, 11, 2);
    drive(1'b0, 1234, 4321, 24576 + 77);
    check_out("gap", 0, -7, 9, 11, 2);
    drive(1'b0, 555, 666, 777);
    check_out("gap2", 0, -7, 9, 11, 2);
    drive(1'b1, 4, 6, 24576 + 3);
    check_out("resume", 1, 6, -4, 3, 3);

    // Reset mid-stream: outputs clear asynchronously and the pending sample is dropped
    @(negedge clk);
    in_valid = 1'b1;
    x_in     = DW'(3333);
    y_in     = DW'(4444);
    theta_in = AW'(9000);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_out("rst_held", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    x_in     = DW'(-300);
    y_in     = DW'(250);
    theta_in = AW'(16384 + 42);
    @(posedge clk);
    #1;
    check_out("post_rst", 1, 300, -250, 42, 2);
    drive(1'b0, 0, 0, 0);
    check_out("post_rst_idle", 0, 300, -250, 42, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_input_standardizer.md
Name: cordic_input_standardizer

Overview:
- Front end of the rotation-mode CORDIC pipeline. Takes a signed vector (x, y) and an unsigned turn-scaled angle.
- Folds the angle into the first quadrant [0, π/2) and pre-rotates the vector by the removed multiple of π/2. The downstream CORDIC micro-rotation stages then only ever see angles below π/2.
- Reports the folded quadrant for the post-processing stage.
- Single registered stage with a valid strobe.

Parameters:
- DATA_W, 16, width of signed x/y samples.
- ANGLE_W, 16, width of the angle port. Only the low 15 bits are significant: full turn = 32768 counts, π/2 = 8192.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  x_in/y_in/theta_in are valid this cycle.
- x_in  input  DATA_W  signed vector x component.
- y_in  input  DATA_W  signed vector y component.
- theta_in  input  ANGLE_W  unsigned angle, 0..32767 = 0..2π; bit 15 ignored.
- out_valid  output  1  outputs valid (registered copy of in_valid).
- x_out  output  DATA_W  signed pre-rotated x.
- y_out  output  DATA_W  signed pre-rotated y.
- theta_out  output  ANGLE_W  residual angle 0..8191, zero-extended.
- quadrant  output  2  quadrant index removed from the angle, 0..3.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, x_out=0, y_out=0, theta_out=0, quadrant=0. Reset deassertion is synchronised by the system; registers update from the first rising edge after release.
- Latency: exactly 1 clock. Outputs register on every rising edge where in_valid=1. No backpressure.
- When in_valid=0, data outputs hold their previous values and out_valid=0 on the next cycle.
- Angle wrap: theta_in[15] is discarded, so 32768 ≡ 0 and 32768+n ≡ n.
- quadrant = theta_in[14:13].
- theta_out = {3'b0, theta_in[12:0]}.
- Exact boundaries fold to residual 0 with the quadrant incremented: 8192→(q1,0), 16384→(q2,0), 24576→(q3,0).
- Pre-rotation by q·π/2, counter-clockwise:
  - q0: (x, y)
  - q1: (−y, x)
  - q2: (−x, −y)
  - q3: (y, −x)
- Negation saturates: −(−32768) = +32767. All other values are exact; no width growth.
- Purely combinational datapath feeding one register bank. No state machine.
- Reset mid-stream: pending sample is dropped; out_valid forced low immediately.

Decomposition:
- Shared package cordic_pkg:
  - ANGLE_FULL_TURN=32768, ANGLE_PI_HALF=8192, ANGLE_PI=16384, ANGLE_3PI_HALF=24576.
  - DATA_W/ANGLE_W defaults.
  - Quadrant encoding constants Q0..Q3 (used by the post-rotator).
  - Function sat_neg(signed DATA_W).
- One natural sub-module: cordic_quadrant_rotate. Combinational (x, y, q) → (x', y') with saturating negation. It is reused by the output de-standardizer.

Test Plan:
- Reset: assert rst_n=0 mid-stream with in_valid=1 → all outputs 0 and out_valid=0 asynchronously; first valid sample after release appears 1 cycle later.
- Angle 0 and small angle:
  - x=16384, y=0, θ=0 → x=16384, y=0, θ=0, q=0.
  - θ=100 → θ=100, q=0.
- Quadrant boundaries:
  - x=10000, y=5000, θ=8192 → x=−5000, y=10000, θ=0, q=1.
  - Same vector, θ=8193 → θ=1, q=1.
  - x=12000, y=−12000, θ=16384 → x=−12000, y=12000, θ=0, q=2.
  - x=2000, y=3000, θ=24576 → x=3000, y=−2000, θ=0, q=3.
- Wrap:
  - x=−15000, y=8000, θ=32767 → x=8000, y=15000, θ=8191, q=3.
  - x=20000, y=1000, θ=32768 → x=20000, y=1000, θ=0, q=0.
- Extremes:
  - x=32767, y=−32767, θ=25000 → x=−32767, y=−32767, θ=424, q=3.
  - x=0, y=−32768, θ=8192 → x=32767 (saturated), y=0, q=1.
  - x=−1, y=−1, θ=1 → unchanged vector, θ=1, q=0.
- Valid gating: back-to-back in_valid for 3 cycles then a 1-cycle gap → out_valid matches, delayed 1 cycle, and outputs hold during the gap.
